// File: rtl/display_digit_scanner.sv
// display_digit_scanner: signed value -> BCD (shift-add-3) -> multiplexed digit codes + one-cold anodes.
// Latency: the display buffer updates DATA_W+1 cycles after the load edge. An error load updates it at the load edge.
// Backpressure: load is dropped while busy is high, including the COMMIT cycle. There is no queueing.
// Optional feature: define BLANK_LEADING_ZEROS_EN to blank leading zeros and float '-' next to the top digit.
`timescale 1ns/1ps

module display_digit_scanner #(
  parameter int DATA_W      = 8,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  input  logic                  error,
  output logic                  busy,
  output logic [3:0]            digit_code,
  output logic [NUM_DIGITS-1:0] anode
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_E     = 4'hC;
  localparam logic [3:0] CODE_MINUS = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    sign_q, sign_d;
  logic [DATA_W:0]         mag_q, mag_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BCD_W-1:0]        buf_q, buf_d;
  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [3:0]              code_q, code_d;

  logic [DATA_W:0]         abs_val;
  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W-1:0]        fmt_buf;
  logic [BCD_W-1:0]        err_buf;

  // Magnitude is one bit wider than the input so that the most negative value negates exactly.
  always_comb begin
    abs_val = {1'b0, value};
    if (value[DATA_W-1]) begin
      abs_val = {1'b0, ~value} + {{DATA_W{1'b0}}, 1'b1};
    end
  end

  // Double-dabble correction: every nibble of 5 or more gets +3 before the next shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Error pattern: 'E' in the rightmost digit and blanks everywhere else.
  always_comb begin
    err_buf = {NUM_DIGITS{CODE_BLANK}};
    err_buf[3:0] = CODE_E;
  end

`ifdef BLANK_LEADING_ZEROS_EN
  // Blank everything above the most significant nonzero digit. The sign takes the first blank slot.
  always_comb begin
    int msd;
    msd = 0;
    fmt_buf = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        msd = i;
      end
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sign_q && (i == msd + 1)) begin
        fmt_buf[4*i +: 4] = CODE_MINUS;
      end else if (i > msd) begin
        fmt_buf[4*i +: 4] = CODE_BLANK;
      end
    end
  end
`else
  // Zero-padded magnitude. A negative value replaces the leftmost digit with '-'.
  always_comb begin
    fmt_buf = bcd_q;
    if (sign_q) begin
      fmt_buf[4*(NUM_DIGITS-1) +: 4] = CODE_MINUS;
    end
  end
`endif

  // Conversion FSM next-state and datapath (IDLE -> CONVERT x DATA_W -> COMMIT -> IDLE).
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          if (error) begin
            buf_d = err_buf;
          end else begin
            sign_d  = value[DATA_W-1];
            mag_d   = abs_val;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = S_CONVERT;
          end
        end
      end
      S_CONVERT: begin
        bcd_d = BCD_W'({bcd_adj, mag_q[DATA_W-1]});
        mag_d = mag_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        buf_d   = fmt_buf;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Free-running digit scan. Outputs are registered from the current index and buffer.
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    anode_d = ~(NUM_DIGITS'(1) << idx_q);
    code_d  = buf_q[{idx_q, 2'b00} +: 4];
  end

  // State registers. A synchronous reset aborts any conversion and blanks the display.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= {NUM_DIGITS{CODE_BLANK}};
      pre_q   <= '0;
      idx_q   <= '0;
      anode_q <= '1;
      code_q  <= CODE_BLANK;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      anode_q <= anode_d;
      code_q  <= code_d;
    end
  end

  assign busy       = busy_q;
  assign anode      = anode_q;
  assign digit_code = code_q;

endmodule

// File: tb/tb_display_digit_scanner.sv
// Directed bench for display_digit_scanner (DATA_W=8, NUM_DIGITS=4, REFRESH_DIV=4).
// Inputs are driven and outputs are sampled on the falling edge. The buffer is read back from the scanned outputs.
// Expected buffers follow BLANK_LEADING_ZEROS_EN when it is defined.
`timescale 1ns/1ps

module tb_display_digit_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] value;
  logic       load;
  logic       error;
  logic       busy;
  logic [3:0] digit_code;
  logic [3:0] anode;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

`ifdef BLANK_LEADING_ZEROS_EN
  localparam logic [15:0] EXP_5   = 16'hAAA5;
  localparam logic [15:0] EXP_M7  = 16'hAAF7;
  localparam logic [15:0] EXP_0   = 16'hAAA0;
  localparam logic [15:0] EXP_42  = 16'hAA42;
  localparam logic [15:0] EXP_3   = 16'hAAA3;
`else
  localparam logic [15:0] EXP_5   = 16'h0005;
  localparam logic [15:0] EXP_M7  = 16'hF007;
  localparam logic [15:0] EXP_0   = 16'h0000;
  localparam logic [15:0] EXP_42  = 16'h0042;
  localparam logic [15:0] EXP_3   = 16'h0003;
`endif

  display_digit_scanner #(
    .DATA_W      (8),
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .load       (load),
    .error      (error),
    .busy       (busy),
    .digit_code (digit_code),
    .anode      (anode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Pulse load for one cycle. Returns at the falling edge after the load edge (cycle 1).
  task automatic do_load(input logic [7:0] v, input logic e);
    value = v;
    error = e;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    error = 1'b0;
  endtask

  // Load a value and idle until the commit has completed (cycle 10).
  task automatic load_and_wait(input logic [7:0] v);
    do_load(v, 1'b0);
    repeat (9) @(negedge clk);
    check("busy_done", {15'd0, busy}, 16'd0);
  endtask

  // Rebuild the 4-digit buffer by watching a full scan. The wait is bounded.
  task automatic read_buf(input string tag, input logic [15:0] exp);
    logic [15:0] d;
    logic [3:0]  got;
    d   = 16'hxxxx;
    got = 4'h0;
    for (int c = 0; c < 40 && got != 4'hF; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (anode === ~(4'b0001 << i)) begin
          d[4*i +: 4] = digit_code;
          got[i]      = 1'b1;
        end
      end
    end
    check({tag, "_scan_complete"}, {12'd0, got}, 16'h000F);
    check(tag, d, exp);
  endtask

  initial begin
    reset = 1'b1;
    value = 8'd0;
    load  = 1'b0;
    error = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_anode", {12'd0, anode}, 16'h000F);
    check("rst_code",  {12'd0, digit_code}, 16'h000A);
    check("rst_busy",  {15'd0, busy}, 16'd0);
    reset = 1'b0;
    check("rel_anode_hold", {12'd0, anode}, 16'h000F);

    // Scan rotation: 4 clocks per digit, starting at digit 0
    for (int k = 1; k <= 17; k++) begin
      logic [3:0] ea;
      @(negedge clk);
      ea = ~(4'b0001 << (((k - 1) / 4) % 4));
      check("scan_anode", {12'd0, anode}, {12'd0, ea});
      check("scan_code",  {12'd0, digit_code}, 16'h000A);
    end

    // Value 5: busy during cycles 1..9, then the buffer updates
    do_load(8'd5, 1'b0);
    check("busy_c1", {15'd0, busy}, 16'd1);
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      check("busy_conv", {15'd0, busy}, 16'd1);
    end
    @(negedge clk);
    check("busy_c10", {15'd0, busy}, 16'd0);
    read_buf("buf_5", EXP_5);

    // Most negative value
    load_and_wait(8'h80);
    read_buf("buf_m128", 16'hF128);

    // -7 and zero
    load_and_wait(8'hF9);
    read_buf("buf_m7", EXP_M7);
    load_and_wait(8'h00);
    read_buf("buf_0", EXP_0);

    // Error load: buffer written at the load edge, busy never rises
    do_load(8'd99, 1'b1);
    check("err_busy_c1", {15'd0, busy}, 16'd0);
    @(negedge clk);
    check("err_busy_c2", {15'd0, busy}, 16'd0);
    read_buf("buf_err", 16'hAAAC);

    // A second load while converting is dropped
    do_load(8'd42, 1'b0);
    @(negedge clk);
    @(negedge clk);
    value = 8'd7;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_42", {15'd0, busy}, 16'd0);
    read_buf("buf_42", EXP_42);

    // A load in the COMMIT cycle is dropped
    do_load(8'd3, 1'b0);
    repeat (8) @(negedge clk);
    check("busy_commit", {15'd0, busy}, 16'd1);
    value = 8'd55;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("busy_after_commit", {15'd0, busy}, 16'd0);
    read_buf("buf_3", EXP_3);

    // Reset during conversion aborts it, and no commit follows
    do_load(8'd77, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy",  {15'd0, busy}, 16'd0);
    check("abort_anode", {12'd0, anode}, 16'h000F);
    repeat (12) @(negedge clk);
    check("abort_busy_late", {15'd0, busy}, 16'd0);
    read_buf("buf_abort", 16'hAAAA);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
